// File: rtl/goldschmidt_sequencer.sv
// goldschmidt_sequencer
//   Iteration controller for a Goldschmidt divider. One external pipelined
//   multiplier (mul_a * mul_b -> mul_p, MUL_LAT cycles later) is time-shared
//   between the numerator and denominator updates of every iteration:
//     N <= N*F, D <= D*F, F <= 2 - D
//   All operands are Q1.23 (for W=24). Products arrive as Q2.46 and are
//   rescaled by taking bits [2W-2:W-1] (truncation).
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      request a division; only sampled while idle
//   dividend   N0, Q1.23, expected in [0.5,1)
//   divisor    D0, Q1.23, expected in [0.5,1); otherwise err is reported
//   busy       high while a division is in flight (not in the done cycle)
//   done       one-cycle pulse; quotient/err valid, held until next start
//   err        divisor was not normalised
//   quotient   Q1.23 result, all ones when err=1
//   mul_a      multiplier operand A (registered)
//   mul_b      multiplier operand B (registered)
//   mul_p      multiplier product, Q2.46

module goldschmidt_sequencer #(
  parameter int W       = 24,
  parameter int ITER    = 5,
  parameter int MUL_LAT = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [W-1:0]   dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_N,
    S_ISSUE_D,
    S_WAIT,
    S_CAPTURE,
    S_FINISH
  } state_t;

  // cyc counts cycles since ISSUE_N; it must reach MUL_LAT+1 (CAPTURE).
  localparam int CW = $clog2(MUL_LAT + 2);
  localparam logic [CW-1:0] LAT_C   = CW'(MUL_LAT);
  localparam logic [3:0]    IT_LAST = 4'(ITER - 1);

  state_t         state_reg, state_next;
  logic [W-1:0]   n_reg, n_next;
  logic [W-1:0]   d_reg, d_next;
  logic [W-1:0]   f_reg, f_next;
  logic [W-1:0]   np_reg, np_next;      // N-product held until CAPTURE
  logic [3:0]     it_reg, it_next;
  logic [CW-1:0]  cyc_reg, cyc_next;
  logic           err_reg, err_next;
  logic [W-1:0]   quot_reg, quot_next;
  logic [W-1:0]   mul_a_reg, mul_a_next;
  logic [W-1:0]   mul_b_reg, mul_b_next;

  // Q2.46 -> Q1.23 by truncation; the top bit cannot be set for legal
  // operands and the low bits are simply dropped.
  logic [W-1:0] prod_scaled;
  logic [W-1:0] prod_neg;
  logic [W-1:0] divisor_neg;
  logic         divisor_ok;
  logic         mul_p_unused;

  assign prod_scaled  = mul_p[2*W-2:W-1];
  assign prod_neg     = -prod_scaled;   // 2 - x in Q1.23 is two's complement mod 2^W
  assign divisor_neg  = -divisor;
  assign divisor_ok   = ~divisor[W-1] & divisor[W-2];
  assign mul_p_unused = ^{mul_p[2*W-1], mul_p[W-2:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      n_reg     <= '0;
      d_reg     <= '0;
      f_reg     <= '0;
      np_reg    <= '0;
      it_reg    <= '0;
      cyc_reg   <= '0;
      err_reg   <= 1'b0;
      quot_reg  <= '0;
      mul_a_reg <= '0;
      mul_b_reg <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      d_reg     <= d_next;
      f_reg     <= f_next;
      np_reg    <= np_next;
      it_reg    <= it_next;
      cyc_reg   <= cyc_next;
      err_reg   <= err_next;
      quot_reg  <= quot_next;
      mul_a_reg <= mul_a_next;
      mul_b_reg <= mul_b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    d_next     = d_reg;
    f_next     = f_reg;
    np_next    = np_reg;
    it_next    = it_reg;
    cyc_next   = cyc_reg;
    err_next   = err_reg;
    quot_next  = quot_reg;
    mul_a_next = mul_a_reg;
    mul_b_next = mul_b_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          n_next   = dividend;
          d_next   = divisor;
          f_next   = divisor_neg;
          it_next  = '0;
          err_next = ~divisor_ok;
          if (divisor_ok) begin
            // Operands are registered, so they must be loaded on the way
            // into ISSUE_N to be on the multiplier during that cycle.
            mul_a_next = dividend;
            mul_b_next = divisor_neg;
            state_next = S_ISSUE_N;
          end else begin
            quot_next  = '1;
            state_next = S_FINISH;
          end
        end
      end

      S_ISSUE_N: begin
        mul_a_next = d_reg;
        mul_b_next = f_reg;
        cyc_next   = CW'(1);
        state_next = S_ISSUE_D;
      end

      // ISSUE_D and WAIT share the counter: the N-product shows up exactly
      // MUL_LAT cycles after ISSUE_N, and the D-product one cycle later,
      // which is the CAPTURE cycle.
      S_ISSUE_D, S_WAIT: begin
        cyc_next = cyc_reg + CW'(1);
        if (cyc_reg == LAT_C) begin
          np_next    = prod_scaled;
          state_next = S_CAPTURE;
        end else begin
          state_next = S_WAIT;
        end
      end

      S_CAPTURE: begin
        n_next  = np_reg;
        d_next  = prod_scaled;
        f_next  = prod_neg;
        it_next = it_reg + 4'd1;
        if (it_reg == IT_LAST) begin
          quot_next  = np_reg;
          state_next = S_FINISH;
        end else begin
          mul_a_next = np_reg;
          mul_b_next = prod_neg;
          state_next = S_ISSUE_N;
        end
      end

      S_FINISH: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_reg != S_IDLE) && (state_reg != S_FINISH);
  assign done     = (state_reg == S_FINISH);
  assign err      = err_reg;
  assign quotient = quot_reg;
  assign mul_a    = mul_a_reg;
  assign mul_b    = mul_b_reg;

endmodule

// File: tb/tb_goldschmidt_sequencer.sv
// Testbench for goldschmidt_sequencer. Three instances share start/operand
// inputs and differ in (ITER, MUL_LAT): (5,1), (3,3), (5,3). Each has its
// own behavioural pipelined multiplier.

module tb_goldschmidt_sequencer;

  localparam int NI = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] dividend;
  logic [23:0] divisor;

  logic        busy_v     [NI];
  logic        done_v     [NI];
  logic        err_v      [NI];
  logic [23:0] quotient_v [NI];
  logic [23:0] mul_a_v    [NI];
  logic [23:0] mul_b_v    [NI];
  logic [47:0] mul_p_v    [NI];

  int iter_of [NI] = '{5, 3, 5};
  int lat_of  [NI] = '{1, 3, 3};

  int errors = 0;
  int checks = 0;

  // results of the most recent run_div
  int          lat_r [NI];
  logic [23:0] q_r   [NI];
  logic        e_r   [NI];

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int IT_G  = (gi == 1) ? 3 : 5;
    localparam int LAT_G = (gi == 0) ? 1 : 3;
    logic [47:0] pipe [0:3];

    always @(posedge clock) begin
      pipe[0] <= mul_a_v[gi] * mul_b_v[gi];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_p_v[gi] = pipe[LAT_G-1];

    goldschmidt_sequencer #(.W(24), .ITER(IT_G), .MUL_LAT(LAT_G)) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy_v[gi]),
      .done     (done_v[gi]),
      .err      (err_v[gi]),
      .quotient (quotient_v[gi]),
      .mul_a    (mul_a_v[gi]),
      .mul_b    (mul_b_v[gi]),
      .mul_p    (mul_p_v[gi])
    );
  end

  // Reference: the truncating Goldschmidt recurrence on integers.
  function automatic logic [23:0] gs_model(input logic [23:0] n0, input logic [23:0] d0,
                                           input int iters);
    logic [23:0] n, d, f, nn;
    logic [47:0] p;
    n = n0; d = d0; f = 24'd0 - d0;
    for (int k = 0; k < iters; k++) begin
      p  = {24'd0, n} * {24'd0, f};
      nn = p[46:23];
      p  = {24'd0, d} * {24'd0, f};
      d  = p[46:23];
      f  = 24'd0 - d;
      n  = nn;
    end
    return n;
  endfunction

  function automatic longint ideal_q(input logic [23:0] n0, input logic [23:0] d0);
    return (longint'(n0) << 23) / longint'(d0);
  endfunction

  // Drive one accepted start and record done cycle / result of each instance.
  // Cycle 0 is the cycle in which start is sampled.
  task automatic run_div(input logic [23:0] dvd, input logic [23:0] dvs);
    int cyc;
    bit all_done;
    @(posedge clock); #1;
    dividend = dvd; divisor = dvs; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin lat_r[i] = -1; q_r[i] = 'x; e_r[i] = 1'bx; end
    cyc = 1;
    all_done = 1'b0;
    while (!all_done && cyc <= 60) begin
      @(negedge clock);
      all_done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (done_v[i] && lat_r[i] < 0) begin
          lat_r[i] = cyc; q_r[i] = quotient_v[i]; e_r[i] = err_v[i];
        end
        if (lat_r[i] < 0) all_done = 1'b0;
      end
      if (!all_done) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    $display("div %h/%h: lat=%0d,%0d,%0d q=%h,%h,%h err=%b%b%b", dvd, dvs,
             lat_r[0], lat_r[1], lat_r[2], q_r[0], q_r[1], q_r[2], e_r[0], e_r[1], e_r[2]);
  endtask

  task automatic settle();
    start = 1'b0;
    repeat (40) @(posedge clock);
    #1;
  endtask

  task automatic check_result(input int i, input logic [23:0] dvd, input logic [23:0] dvs,
                              input string tag);
    logic [23:0] exp_q;
    longint diff;
    int exp_lat;
    exp_lat = iter_of[i] * (lat_of[i] + 2) + 1;
    exp_q = gs_model(dvd, dvs, iter_of[i]);
    checks++;
    if (lat_r[i] !== exp_lat) begin
      errors++;
      $display("FAIL %s_lat[%0d]: got %0d expected %0d", tag, i, lat_r[i], exp_lat);
    end
    checks++;
    if (e_r[i] !== 1'b0) begin
      errors++;
      $display("FAIL %s_err[%0d]: got %b expected 0", tag, i, e_r[i]);
    end
    checks++;
    if (q_r[i] !== exp_q) begin
      errors++;
      $display("FAIL %s_q[%0d]: got %h expected %h", tag, i, q_r[i], exp_q);
    end
    if (iter_of[i] >= 5) begin
      // truncation normally lands at or below the ideal; a few LSB of slack
      // above is tolerated
      diff = ideal_q(dvd, dvs) - longint'(q_r[i]);
      checks++;
      if (diff < -8 || diff > 8) begin
        errors++;
        $display("FAIL %s_acc[%0d]: got %h ideal %h", tag, i, q_r[i], ideal_q(dvd, dvs));
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(posedge clock); #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({busy_v[i], done_v[i], err_v[i]} !== 3'b000 || quotient_v[i] !== 24'd0 ||
          mul_a_v[i] !== 24'd0 || mul_b_v[i] !== 24'd0) begin
        errors++;
        $display("FAIL reset[%0d]: got busy=%b done=%b err=%b q=%h a=%h b=%h expected all 0",
                 i, busy_v[i], done_v[i], err_v[i], quotient_v[i], mul_a_v[i], mul_b_v[i]);
      end
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  // 0.75 / 0.5: hand-traced recurrence gives 0xBFFFFF; final D=1-2^-16, F=1+2^-16.
  task automatic test_basic();
    run_div(24'h600000, 24'h400000);
    checks++;
    if (lat_r[0] !== 16) begin
      errors++; $display("FAIL basic_lat: got %0d expected 16", lat_r[0]);
    end
    checks++;
    if (q_r[0] !== 24'hBFFFFF || e_r[0] !== 1'b0) begin
      errors++; $display("FAIL basic_q: got %h err=%b expected bfffff err=0", q_r[0], e_r[0]);
    end
    checks++;
    if (!(q_r[0] >= 24'hBFFFF8 && q_r[0] <= 24'hC00000)) begin
      errors++; $display("FAIL basic_range: got %h expected bffff8..c00000", q_r[0]);
    end
    checks++;
    if (mul_a_v[0] !== 24'h7FFF80 || mul_b_v[0] !== 24'h800080) begin
      errors++;
      $display("FAIL basic_mul_hold: got a=%h b=%h expected a=7fff80 b=800080", mul_a_v[0], mul_b_v[0]);
    end
    checks++;
    if (quotient_v[0] !== 24'hBFFFFF || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got q=%h busy=%b done=%b expected bfffff 0 0",
               quotient_v[0], busy_v[0], done_v[0]);
    end
    check_result(1, 24'h600000, 24'h400000, "basic");
    check_result(2, 24'h600000, 24'h400000, "basic");
  endtask

  task automatic test_err();
    run_div(24'h600000, 24'h200000);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (lat_r[i] !== 1 || e_r[i] !== 1'b1 || q_r[i] !== 24'hFFFFFF) begin
        errors++;
        $display("FAIL err[%0d]: got lat=%0d err=%b q=%h expected lat=1 err=1 q=ffffff",
                 i, lat_r[i], e_r[i], q_r[i]);
      end
    end
    checks++;
    if (mul_a_v[0] !== 24'h7FFF80 || mul_b_v[0] !== 24'h800080) begin
      errors++;
      $display("FAIL err_no_issue: got a=%h b=%h expected a=7fff80 b=800080", mul_a_v[0], mul_b_v[0]);
    end
    checks++;
    if (err_v[0] !== 1'b1 || quotient_v[0] !== 24'hFFFFFF) begin
      errors++; $display("FAIL err_hold: got err=%b q=%h expected 1 ffffff", err_v[0], quotient_v[0]);
    end
    run_div(24'h400000, 24'h800000);   // bit23 set: also illegal
    checks++;
    if (lat_r[0] !== 1 || e_r[0] !== 1'b1 || q_r[0] !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL err_bit23: got lat=%0d err=%b q=%h expected 1 1 ffffff", lat_r[0], e_r[0], q_r[0]);
    end
  endtask

  task automatic test_ratio();
    settle();
    run_div(24'h456789, 24'h654321);   // err must clear on this accepted start
    for (int i = 0; i < NI; i++) check_result(i, 24'h456789, 24'h654321, "ratio");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int first_cyc;
    int dones;
    logic [23:0] q1;
    logic [23:0] exp1;
    logic [23:0] exp2;
    exp1 = gs_model(24'h500000, 24'h700000, 5);
    exp2 = gs_model(24'h480000, 24'h5A0000, 5);
    settle();
    @(posedge clock); #1;
    dividend = 24'h500000; divisor = 24'h700000; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    dones = 0; first_cyc = -1; q1 = '0;
    for (cyc = 1; cyc <= 16; cyc++) begin
      if (cyc == 5) begin dividend = 24'h7FFFFF; divisor = 24'h400000; start = 1'b1; end
      if (cyc == 6) start = 1'b0;
      @(negedge clock);
      if (done_v[0]) begin
        dones++;
        if (first_cyc < 0) begin first_cyc = cyc; q1 = quotient_v[0]; end
      end
      if (cyc < 16) begin @(posedge clock); #1; end
    end
    checks++;
    if (dones !== 1 || first_cyc !== 16) begin
      errors++; $display("FAIL ignore_done: got %0d pulses at %0d expected 1 at 16", dones, first_cyc);
    end
    checks++;
    if (q1 !== exp1) begin
      errors++; $display("FAIL ignore_q: got %h expected %h", q1, exp1);
    end
    // start raised during the done cycle must be ignored; accepted in the next
    dividend = 24'h480000; divisor = 24'h5A0000; start = 1'b1;
    @(posedge clock); #1;            // idle cycle (cycle 0 of the new division)
    @(posedge clock); #1;
    start = 1'b0;
    first_cyc = -1;
    for (cyc = 1; cyc <= 30 && first_cyc < 0; cyc++) begin
      @(negedge clock);
      if (done_v[0]) begin first_cyc = cyc; q1 = quotient_v[0]; end
      @(posedge clock); #1;
    end
    $display("b2b 480000/5a0000: lat=%0d q=%h", first_cyc, q1);
    checks++;
    if (first_cyc !== 16) begin
      errors++; $display("FAIL b2b_lat: got %0d expected 16", first_cyc);
    end
    checks++;
    if (q1 !== exp2) begin
      errors++; $display("FAIL b2b_q: got %h expected %h", q1, exp2);
    end
  endtask

  // Instance 2 (ITER=5, MUL_LAT=3): iteration 3 spans cycles 11..15, WAIT is 13..14.
  task automatic test_reset_mid();
    int seen_done;
    settle();
    @(posedge clock); #1;
    dividend = 24'h6A0000; divisor = 24'h4C0000; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    checks++;
    if (busy_v[2] !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got busy=%b expected 1", busy_v[2]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0 || mul_a_v[2] !== 24'd0 ||
        mul_b_v[2] !== 24'd0 || quotient_v[2] !== 24'd0) begin
      errors++;
      $display("FAIL rstmid_now: got busy=%b done=%b a=%h b=%h q=%h expected all 0",
               busy_v[2], done_v[2], mul_a_v[2], mul_b_v[2], quotient_v[2]);
    end
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      for (int i = 0; i < NI; i++) if (done_v[i] !== 1'b0) seen_done++;
      if (k == 2) reset_n = 1'b1;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++; $display("FAIL rstmid_no_done: got %0d done cycles expected 0", seen_done);
    end
    run_div(24'h6A0000, 24'h4C0000);
    for (int i = 0; i < NI; i++) check_result(i, 24'h6A0000, 24'h4C0000, "rstmid");
  endtask

  task automatic test_sweep();
    logic [23:0] dvd, dvs;
    for (int v = 0; v < 4; v++) begin
      dvs = 24'($urandom_range(32'h7FFFFF, 32'h400001));
      dvd = 24'($urandom_range(32'(dvs) - 1, 32'h400000));
      run_div(dvd, dvs);
      for (int i = 0; i < NI; i++) check_result(i, dvd, dvs, "sweep");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_ratio();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
